decode_execute_pipe: RTL and testbench

//  Decode->Execute pipeline register of the 5-stage RV32I core; sits directly downstream of the register file.

---
 rtl/decode_execute_pipe.sv | 144 ++++++++++++++
 tb/tb_decode_execute_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe.sv
// Decode->Execute pipeline register for the RV32I core: captures operands (with
// write-first bypass of the same-cycle writeback), control and PC/immediate.
module decode_execute_pipe #(
  parameter int unsigned WAD = 5,
  parameter int unsigned WD  = 32,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stallE,
  input  logic           flushE,
  input  logic           validD,
  input  logic [WAD-1:0] adin1D,
  input  logic [WAD-1:0] adin2D,
  input  logic [WAD-1:0] rdD,
  input  logic [WD-1:0]  RD1D,
  input  logic [WD-1:0]  RD2D,
  input  logic           regwriteW,
  input  logic [WAD-1:0] rdW,
  input  logic [WD-1:0]  resultW,
  input  logic [WD-1:0]  pcD,
  input  logic [WD-1:0]  pcplus4D,
  input  logic [WD-1:0]  immextD,
  input  logic [9:0]     ctrlD,
  output logic           validE,
  output logic [WD-1:0]  RD1E,
  output logic [WD-1:0]  RD2E,
  output logic [WAD-1:0] rs1E,
  output logic [WAD-1:0] rs2E,
  output logic [WAD-1:0] rdE,
  output logic [WD-1:0]  pcE,
  output logic [WD-1:0]  pcplus4E,
  output logic [WD-1:0]  immextE,
  output logic [9:0]     ctrlE,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  bubble_cnt
);

  logic           valid_q, valid_d;
  logic [WD-1:0]  rd1_q, rd1_d, rd2_q, rd2_d;
  logic [WAD-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WD-1:0]  pc_q, pc_d, pcplus4_q, pcplus4_d, immext_q, immext_d;
  logic [9:0]     ctrl_q, ctrl_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  // x0 reads as zero; a write to x0 never forwards
  function automatic logic [WD-1:0] bypass(input logic [WAD-1:0] adr,
                                           input logic [WD-1:0]  rf_data);
    if (adr == '0)
      return '0;
    else if (regwriteW && (rdW != '0) && (rdW == adr))
      return resultW;
    else
      return rf_data;
  endfunction

  always_comb begin
    valid_d      = valid_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    pcplus4_d    = pcplus4_q;
    immext_d     = immext_q;
    ctrl_d       = ctrl_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flushE || (!stallE && !validD)) begin
      valid_d   = 1'b0;
      rd1_d     = '0;
      rd2_d     = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      pc_d      = '0;
      pcplus4_d = '0;
      immext_d  = '0;
      ctrl_d    = '0;
      if (bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else if (stallE) begin
      if (stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      valid_d   = 1'b1;
      rd1_d     = bypass(adin1D, RD1D);
      rd2_d     = bypass(adin2D, RD2D);
      rs1_d     = adin1D;
      rs2_d     = adin2D;
      rd_d      = rdD;
      pc_d      = pcD;
      pcplus4_d = pcplus4D;
      immext_d  = immextD;
      ctrl_d    = ctrlD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      pcplus4_q    <= '0;
      immext_q     <= '0;
      ctrl_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      pcplus4_q    <= pcplus4_d;
      immext_q     <= immext_d;
      ctrl_q       <= ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign validE     = valid_q;
  assign RD1E       = rd1_q;
  assign RD2E       = rd2_q;
  assign rs1E       = rs1_q;
  assign rs2E       = rs2_q;
  assign rdE        = rd_q;
  assign pcE        = pc_q;
  assign pcplus4E   = pcplus4_q;
  assign immextE    = immext_q;
  assign ctrlE      = ctrl_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe: default build plus a CW=4 build for
// counter saturation, both driven from the same stimulus.
module tb_decode_execute_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallE, flushE, validD, regwriteW;
  logic [4:0]  adin1D, adin2D, rdD, rdW;
  logic [31:0] RD1D, RD2D, resultW, pcD, pcplus4D, immextD;
  logic [9:0]  ctrlD;

  logic        validE, validE_s;
  logic [31:0] RD1E, RD2E, pcE, pcplus4E, immextE;
  logic [31:0] RD1E_s, RD2E_s, pcE_s, pcplus4E_s, immextE_s;
  logic [4:0]  rs1E, rs2E, rdE, rs1E_s, rs2E_s, rdE_s;
  logic [9:0]  ctrlE, ctrlE_s;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [3:0]  stall_cnt_s, bubble_cnt_s;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  decode_execute_pipe #(.WAD(5), .WD(32), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validD(validD),
    .adin1D(adin1D), .adin2D(adin2D), .rdD(rdD), .RD1D(RD1D), .RD2D(RD2D),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .pcD(pcD),
    .pcplus4D(pcplus4D), .immextD(immextD), .ctrlD(ctrlD),
    .validE(validE), .RD1E(RD1E), .RD2E(RD2E), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .pcE(pcE), .pcplus4E(pcplus4E), .immextE(immextE),
    .ctrlE(ctrlE), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  decode_execute_pipe #(.WAD(5), .WD(32), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validD(validD),
    .adin1D(adin1D), .adin2D(adin2D), .rdD(rdD), .RD1D(RD1D), .RD2D(RD2D),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .pcD(pcD),
    .pcplus4D(pcplus4D), .immextD(immextD), .ctrlD(ctrlD),
    .validE(validE_s), .RD1E(RD1E_s), .RD2E(RD2E_s), .rs1E(rs1E_s), .rs2E(rs2E_s),
    .rdE(rdE_s), .pcE(pcE_s), .pcplus4E(pcplus4E_s), .immextE(immextE_s),
    .ctrlE(ctrlE_s), .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one active edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    stallE    = $urandom_range(0, 1);
    flushE    = $urandom_range(0, 1);
    validD    = $urandom_range(0, 1);
    regwriteW = $urandom_range(0, 1);
    adin1D    = 5'($urandom);
    adin2D    = 5'($urandom);
    rdD       = 5'($urandom);
    rdW       = 5'($urandom);
    RD1D      = $urandom;
    RD2D      = $urandom;
    resultW   = $urandom;
    pcD       = $urandom;
    pcplus4D  = $urandom;
    immextD   = $urandom;
    ctrlD     = 10'($urandom);

    // reset state under random inputs
    #2;
    chk("rst_validE", {31'd0, validE}, 32'd0);
    chk("rst_RD1E", RD1E, 32'd0);
    chk("rst_pcE", pcE, 32'd0);
    chk("rst_ctrlE", {22'd0, ctrlE}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    step();
    chk("rst_hold_rdE", {27'd0, rdE}, 32'd0);

    // first capture with rs1 bypass from writeback
    stallE = 1'b0; flushE = 1'b0; validD = 1'b1;
    adin1D = 5'd5; RD1D = 32'h11; adin2D = 5'd3; RD2D = 32'h22; rdD = 5'd7;
    regwriteW = 1'b1; rdW = 5'd5; resultW = 32'hDEAD;
    pcD = 32'h100; pcplus4D = 32'h104; immextD = 32'h8; ctrlD = 10'h2AB;
    rst_n = 1'b1;
    step();
    chk("byp_RD1E", RD1E, 32'hDEAD);
    chk("byp_RD2E", RD2E, 32'h22);
    chk("load_validE", {31'd0, validE}, 32'd1);
    chk("load_rs1E", {27'd0, rs1E}, 32'd5);
    chk("load_rdE", {27'd0, rdE}, 32'd7);
    chk("load_pcplus4E", pcplus4E, 32'h104);
    chk("load_immextE", immextE, 32'h8);
    chk("load_ctrlE", {22'd0, ctrlE}, 32'h2AB);

    rdW = 5'd6;
    step();
    chk("nobyp_RD1E", RD1E, 32'h11);

    // x0 source and rdW=0 writeback
    adin2D = 5'd0; RD2D = 32'hFFFF; rdW = 5'd0; resultW = 32'd7;
    adin1D = 5'd0; RD1D = 32'h55;
    step();
    chk("x0_RD2E", RD2E, 32'd0);
    chk("x0_rs2E", {27'd0, rs2E}, 32'd0);
    chk("x0_RD1E", RD1E, 32'd0);
    adin1D = 5'd9; RD1D = 32'h99;
    step();
    chk("rdw0_RD1E", RD1E, 32'h99);

    // stall holds all E fields, held operand not re-bypassed
    pcD = 32'h100; adin1D = 5'd4; RD1D = 32'h44; rdW = 5'd6;
    step();
    chk("pre_stall_pcE", pcE, 32'h100);
    stallE = 1'b1; pcD = 32'h104; RD1D = 32'h77; rdW = 5'd4; resultW = 32'hBEEF;
    repeat (3) step();
    chk("stall_pcE", pcE, 32'h100);
    chk("stall_RD1E", RD1E, 32'h44);
    chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    chk("stall_bubble0", {16'd0, bubble_cnt}, 32'd0);

    // flush wins over stall
    flushE = 1'b1; ctrlD = 10'h3FF;
    step();
    chk("flush_validE", {31'd0, validE}, 32'd0);
    chk("flush_ctrlE", {22'd0, ctrlE}, 32'd0);
    chk("flush_pcE", pcE, 32'd0);
    chk("flush_bubble", {16'd0, bubble_cnt}, 32'd1);
    chk("flush_stall_same", {16'd0, stall_cnt}, 32'd3);

    // invalid decode loads a bubble
    flushE = 1'b0; stallE = 1'b0; validD = 1'b1; adin1D = 5'd2; rdD = 5'd12;
    step();
    chk("reload_validE", {31'd0, validE}, 32'd1);
    validD = 1'b0;
    step();
    chk("inv_validE", {31'd0, validE}, 32'd0);
    chk("inv_ctrlE", {22'd0, ctrlE}, 32'd0);
    chk("inv_rdE", {27'd0, rdE}, 32'd0);
    chk("inv_rs1E", {27'd0, rs1E}, 32'd0);
    chk("inv_bubble", {16'd0, bubble_cnt}, 32'd2);

    // async reset mid-stall
    validD = 1'b1; pcD = 32'h200;
    step();
    stallE = 1'b1;
    step();
    chk("pre_rst_pcE", pcE, 32'h200);
    rst_n = 1'b0;
    #1;
    chk("arst_pcE", pcE, 32'd0);
    chk("arst_validE", {31'd0, validE}, 32'd0);
    chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);

    // saturation on the CW=4 build
    step();
    rst_n = 1'b1;
    repeat (15) step();
    chk("sat_cnt15", {28'd0, stall_cnt_s}, 32'd15);
    repeat (6) step();
    chk("sat_hold", {28'd0, stall_cnt_s}, 32'd15);
    chk("sat_wide_cnt", {16'd0, stall_cnt}, 32'd21);
    chk("sat_pcE", pcE_s, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
